ram_write_arbiter: RTL and testbench
====================================

// Module: ram_write_arbiter
// PURPOSE
//  Shares the single write port of a dual-clock block RAM (framebuffer/texture store) between two requesters.
//  Adds a built-in clear sequencer that sweeps every address with a fill value, one write per cycle.
//  Replaces in-RAM reset loops; sits in the write-clock domain, directly in front of the RAM write port.
// PARAMETERS
//  WIDTH      8  data width of one RAM word
//  ADDR_BITS  8  RAM address width; depth = 2**ADDR_BITS
// PORTS
//  clk_i               in   1          write-domain clock; all logic on rising edge
//  reset_ni            in   1          asynchronous, active-low reset
//  req0_valid_i        in   1          requester 0 has a write pending
//  req0_ready_o        out  1          requester 0 write accepted this cycle
//  req0_addr_i         in   ADDR_BITS  requester 0 write address
//  req0_data_i         in   WIDTH      requester 0 write data
//  req1_valid_i        in   1          requester 1 has a write pending
//  req1_ready_o        out  1          requester 1 write accepted this cycle
//  req1_addr_i         in   ADDR_BITS  requester 1 write address
//  req1_data_i         in   WIDTH      requester 1 write data
//  clear_start_i       in   1          pulse: start a full-RAM clear
//  clear_value_i       in   WIDTH      fill value, sampled with clear_start_i
//  clear_busy_o        out  1          high while clear writes are on the RAM port
//  clear_done_o        out  1          one-cycle pulse with the final clear write
//  ram_write_enable_o  out  1          to RAM write_enable_i (registered)
//  ram_write_addr_o    out  ADDR_BITS  to RAM write_addr_i (registered)
//  ram_write_data_o    out  WIDTH      to RAM write_data_i (registered)
// BEHAVIOUR
//  - Reset (reset_ni low, async): all outputs 0; state ARB; clear counter 0; RR pointer -> req0.
//  - States: ARB (serve requesters) and CLEAR (sweep). ARB->CLEAR on clear_start_i; CLEAR->ARB after last address.
//  - Handshake: transfer when valid & ready; the requester holds valid/addr/data stable until ready.
//  - ready is combinational from the valids and state; at most one ready high per cycle; ready never high without valid.
//  - Write latency 1: transfer in cycle N -> ram_write_enable_o=1 with that addr/data in cycle N+1.
//  - No transfer in a cycle -> ram_write_enable_o=0 next cycle; addr/data hold their previous values.
//  - Fixed priority (default): req0 wins when both valid; req1 starves while req0 stays valid.
//  - clear_start_i high in ARB at cycle N: both readies 0 in cycle N, even if valid.
//    The clear takes priority over any pending request, and clear_value_i is latched.
//  - Clear sweep: ram_write_enable_o=1 in cycles N+1 .. N+2**ADDR_BITS.
//    Addresses are 0,1,..,2**ADDR_BITS-1 in order; data = the latched value.
//  - clear_busy_o is high in exactly those cycles; both readies are 0 throughout.
//  - clear_done_o pulses with the final write (addr all-ones); requests are accepted again from cycle N+2**ADDR_BITS+1.
//  - Counter is ADDR_BITS wide; terminal count is all-ones (no extra bit, no wrap past it).
//  - clear_start_i while in CLEAR is ignored: no restart, no queued second clear.
//  - Reset during CLEAR aborts the sweep: no done pulse, write enable drops immediately, state ARB.
// CONFIGURATION
//  RAM_ARB_ROUND_ROBIN_EN defined: round-robin when both valid.
//   - Priority goes to the requester not granted most recently; the pointer updates only on a transfer.
//   - After reset the pointer favours req0.
//   - A clear does not move the pointer.
//  Undefined: fixed priority, req0 over req1; no pointer state exists.
// TESTING
//  1. Fixed prio: both valid (a0=3,d0=AA; a1=5,d1=55) for 2 cycles.
//     -> req0 accepted twice; RAM sees addr 3/AA on both following cycles; req1_ready_o stays 0.
//  2. RR_EN: both valid for 4 cycles -> grants req0,req1,req0,req1; RAM addr sequence 3,5,3,5, each one cycle after its grant.
//  3. ADDR_BITS=4, clear_start_i pulse, value 0x7E.
//     -> 16 consecutive writes, addr 0..15, data 7E; busy high 16 cycles; done high only with addr 15.
//  4. req1_valid_i asserted mid-clear (a=9,d=11) -> ready low until the sweep ends.
//     -> accepted in the first cycle after busy falls; RAM then writes addr 9/11.
//  5. clear_start_i and req0_valid_i in the same cycle -> req0_ready_o=0 that cycle.
//     -> clear runs to completion first; req0 is written afterwards.
//  6. reset_ni low after the 5th clear write -> all outputs 0 at once; no done pulse.
//     -> after release a request (a=2,d=C3) is written with 1-cycle latency.

Source files
------------

// File: rtl/ram_write_arbiter_if.sv
// Write-port bundle between two requesters, the clear control and the RAM write port.
interface ram_write_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [ADDR_BITS-1:0] req0_addr;
    logic [WIDTH-1:0]     req0_data;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [ADDR_BITS-1:0] req1_addr;
    logic [WIDTH-1:0]     req1_data;
    logic                 clear_start;
    logic [WIDTH-1:0]     clear_value;
    logic                 clear_busy;
    logic                 clear_done;
    logic                 ram_write_enable;
    logic [ADDR_BITS-1:0] ram_write_addr;
    logic [WIDTH-1:0]     ram_write_data;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clear_start, clear_value,
        output req0_ready, req1_ready, clear_busy, clear_done,
        output ram_write_enable, ram_write_addr, ram_write_data
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clear_start, clear_value,
        input  req0_ready, req1_ready, clear_busy, clear_done,
        input  ram_write_enable, ram_write_addr, ram_write_data
    );
endinterface

// File: rtl/ram_write_arbiter.sv
// Two-requester arbiter for a RAM write port with a built-in full-RAM clear sweep.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to req0.
module ram_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    ram_write_arbiter_if.slave  bus
);
    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t               state;
    logic [ADDR_BITS-1:0] cnt;
    logic                 we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WIDTH-1:0]     data_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 grant0;
    logic                 grant1;
    logic                 arb_open;

    // A clear request in ARB closes the port in the same cycle it is seen.
    assign arb_open = (state == ARB) && !bus.clear_start;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic prio1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (arb_open) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = !prio1;
                grant1 = prio1;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    // Favour whoever was not served last; clears leave the pointer alone.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)   prio1 <= 1'b0;
        else if (grant0) prio1 <= 1'b1;
        else if (grant1) prio1 <= 1'b0;
    end
`else
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (arb_open) begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid && !bus.req0_valid;
        end
    end
`endif

    assign bus.req0_ready       = grant0;
    assign bus.req1_ready       = grant1;
    assign bus.ram_write_enable = we_q;
    assign bus.ram_write_addr   = addr_q;
    assign bus.ram_write_data   = data_q;
    assign bus.clear_busy       = busy_q;
    assign bus.clear_done       = done_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state  <= ARB;
            cnt    <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    done_q <= 1'b0;
                    if (bus.clear_start) begin
                        // Fill value lives in data_q for the whole sweep.
                        state  <= CLEAR;
                        cnt    <= '0;
                        we_q   <= 1'b1;
                        addr_q <= '0;
                        data_q <= bus.clear_value;
                        busy_q <= 1'b1;
                    end else if (grant0) begin
                        we_q   <= 1'b1;
                        addr_q <= bus.req0_addr;
                        data_q <= bus.req0_data;
                    end else if (grant1) begin
                        we_q   <= 1'b1;
                        addr_q <= bus.req1_addr;
                        data_q <= bus.req1_data;
                    end else begin
                        we_q   <= 1'b0;
                    end
                end
                CLEAR: begin
                    // cnt is the address currently on the RAM port.
                    if (cnt == LAST_ADDR) begin
                        state  <= ARB;
                        we_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        addr_q <= cnt + 1'b1;
                        we_q   <= 1'b1;
                        done_q <= (cnt == LAST_ADDR - 1'b1);
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_write_arbiter.sv
// Directed plus randomized bench for ram_write_arbiter against a cycle-level reference model.
module tb_ram_write_arbiter;
    localparam int W     = 8;
    localparam int A     = 4;
    localparam int DEPTH = 1 << A;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ram_write_arbiter_if #(.WIDTH(W), .ADDR_BITS(A)) bus ();

    ram_write_arbiter #(.WIDTH(W), .ADDR_BITS(A)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // staged inputs, applied at the next falling edge
    logic         s_v0, s_v1, s_cs;
    logic [A-1:0] s_a0, s_a1;
    logic [W-1:0] s_d0, s_d1, s_cv;

    // reference model: expected registered outputs for the current cycle
    logic         m_we, m_busy, m_done;
    int           m_addr, m_data;
    int           sweep_next;
    int           last_grant;
    int           g;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_we = 0; m_busy = 0; m_done = 0; m_addr = 0; m_data = 0;
        sweep_next = DEPTH;
        last_grant = 1;
        g = -1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"},   int'(bus.ram_write_enable), 0);
        chk({tag, "_addr"}, int'(bus.ram_write_addr), 0);
        chk({tag, "_data"}, int'(bus.ram_write_data), 0);
        chk({tag, "_busy"}, int'(bus.clear_busy), 0);
        chk({tag, "_done"}, int'(bus.clear_done), 0);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.req0_valid = s_v0; bus.req0_addr = s_a0; bus.req0_data = s_d0;
        bus.req1_valid = s_v1; bus.req1_addr = s_a1; bus.req1_data = s_d1;
        bus.clear_start = s_cs; bus.clear_value = s_cv;
        #1;
        g = -1;
        if (!m_busy && !s_cs) begin
            if (s_v0 && s_v1) g = (RR && last_grant == 0) ? 1 : 0;
            else if (s_v0)    g = 0;
            else if (s_v1)    g = 1;
        end
        chk("ready0", int'(bus.req0_ready), int'(g == 0));
        chk("ready1", int'(bus.req1_ready), int'(g == 1));
        chk("we",     int'(bus.ram_write_enable), int'(m_we));
        chk("addr",   int'(bus.ram_write_addr), m_addr);
        chk("data",   int'(bus.ram_write_data), m_data);
        chk("busy",   int'(bus.clear_busy), int'(m_busy));
        chk("done",   int'(bus.clear_done), int'(m_done));
        if (m_busy) begin
            if (sweep_next < DEPTH) begin
                m_we = 1; m_addr = sweep_next; m_done = (sweep_next == DEPTH - 1);
                sweep_next++;
            end else begin
                m_we = 0; m_busy = 0; m_done = 0;
            end
        end else if (s_cs) begin
            m_we = 1; m_busy = 1; m_done = 0; m_addr = 0; m_data = int'(s_cv);
            sweep_next = 1;
        end else if (g == 0) begin
            m_we = 1; m_addr = int'(s_a0); m_data = int'(s_d0); last_grant = 0;
        end else if (g == 1) begin
            m_we = 1; m_addr = int'(s_a1); m_data = int'(s_d1); last_grant = 1;
        end else begin
            m_we = 0;
        end
    endtask

    task automatic idle_inputs();
        s_v0 = 0; s_v1 = 0; s_cs = 0;
        s_a0 = '0; s_a1 = '0; s_d0 = '0; s_d1 = '0; s_cv = '0;
    endtask

    logic         p0, p1;
    logic [A-1:0] pa0, pa1;
    logic [W-1:0] pd0, pd1;

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.clear_start = 0; bus.clear_value = '0;
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("rst");
        chk("rst_ready0", int'(bus.req0_ready), 0);
        rst_n = 1'b1;

        // both requesters valid: fixed priority serves req0, round-robin alternates
        s_v0 = 1; s_a0 = 4'd3; s_d0 = 8'hAA;
        s_v1 = 1; s_a1 = 4'd5; s_d1 = 8'h55;
        repeat (4) tick();
        idle_inputs();
        repeat (2) tick();

        // clear sweep of the whole RAM with 0x7E
        s_cs = 1; s_cv = 8'h7E;
        tick();
        s_cs = 0;
        repeat (3) tick();
        // req1 arrives mid-clear and must wait for the sweep to finish
        s_v1 = 1; s_a1 = 4'd9; s_d1 = 8'h11;
        // a second start during the sweep is ignored
        s_cs = 1; s_cv = 8'h01;
        tick();
        s_cs = 0;
        while (s_v1) begin
            tick();
            if (g == 1) s_v1 = 0;
            if (checks > 2000) begin
                chk("req1_timeout", 1, 0);
                s_v1 = 0;
            end
        end
        repeat (2) tick();

        // clear and req0 in the same cycle: clear first, req0 afterwards
        s_cs = 1; s_cv = 8'h3C;
        s_v0 = 1; s_a0 = 4'd7; s_d0 = 8'h99;
        tick();
        s_cs = 0;
        repeat (40) begin
            if (s_v0) begin
                tick();
                if (g == 0) s_v0 = 0;
            end
        end
        chk("req0_served", int'(s_v0), 0);
        idle_inputs();
        repeat (2) tick();

        // reset after the 5th clear write aborts the sweep
        s_cs = 1; s_cv = 8'hE1;
        tick();
        s_cs = 0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        repeat (2) begin
            @(negedge clk);
            #1;
            chk_zero("hold");
        end
        rst_n = 1'b1;
        model_reset();
        s_v0 = 1; s_a0 = 4'd2; s_d0 = 8'hC3;
        tick();
        s_v0 = 0;
        repeat (2) tick();

        // randomized traffic with occasional clears
        p0 = 0; p1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        repeat (400) begin
            if (!p0 && ($urandom % 3 == 0)) begin
                p0 = 1; pa0 = A'($urandom); pd0 = W'($urandom);
            end
            if (!p1 && ($urandom % 3 == 0)) begin
                p1 = 1; pa1 = A'($urandom); pd1 = W'($urandom);
            end
            s_v0 = p0; s_a0 = pa0; s_d0 = pd0;
            s_v1 = p1; s_a1 = pa1; s_d1 = pd1;
            s_cs = ($urandom % 60 == 0);
            s_cv = W'($urandom);
            tick();
            if (g == 0) p0 = 0;
            if (g == 1) p1 = 0;
        end
        idle_inputs();
        repeat (DEPTH + 2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
